// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI master transaction engine among NREQ
// requesters: grant, single-cycle trigger, bounded wait for completion, done pulse.
module spi_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [DW-1:0]        rsp_data,
    output logic                 busy,
    output logic                 spi_trigger,
    output logic [DW-1:0]        spi_din,
    input  logic [DW-1:0]        spi_dout,
    input  logic                 spi_trigger_out,
    output logic [1:0]           dbg_state
);

    // Handshake: a requester holds req high until the cycle its done bit pulses;
    // gnt marks the owner from grant through that done cycle, and err qualifies
    // done. Towards the master, spi_trigger is a one-cycle start and
    // spi_trigger_out a one-cycle completion carrying spi_dout.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rsp_q, rsp_d;
    logic            trig_q, trig_d;
    logic [DW-1:0]   din_q, din_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW:0]     idx_sum;
    logic [PW-1:0]   ptr_next;

    // Scan from ptr upward with wrap; the first set req bit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx_sum >= (PW+1)'(NREQ)) begin
                idx_sum = idx_sum - (PW+1)'(NREQ);
            end
            if (!win_found && req[idx_sum[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx_sum[PW-1:0];
            end
        end
    end

    assign ptr_next = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        timer_d = timer_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        err_d   = err_q;
        rsp_d   = rsp_q;
        trig_d  = trig_q;
        din_d   = din_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    din_d          = req_data[int'(win_idx) * DW +: DW];
                    trig_d         = 1'b1;
                    timer_d        = '0;
                    state_d        = ST_WAIT;
                end
            end
            ST_WAIT: begin
                trig_d = 1'b0;
                if (timer_q != TMAX) begin
                    timer_d = timer_q + TW'(1);
                end
                // A completion seen while our own trigger is still high cannot
                // belong to this transaction, so it is not accepted.
                if (spi_trigger_out && !trig_q) begin
                    rsp_d   = spi_dout;
                    err_d   = 1'b0;
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else if (timer_q == TMAX) begin
                    err_d   = 1'b1;
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = '0;
                gnt_d   = '0;
                ptr_d   = ptr_next;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            timer_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rsp_q   <= '0;
            trig_q  <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
            trig_q  <= trig_d;
            din_q   <= din_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rsp_data    = rsp_q;
    assign spi_trigger = trig_q;
    assign spi_din     = din_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: a transaction table driven through a
// master model, plus hand sequences for fairness, spurious completions and reset.
module tb_spi_req_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 100;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [DW-1:0]        rsp_data;
    logic                 busy;
    logic                 spi_trigger;
    logic [DW-1:0]        spi_din;
    logic [DW-1:0]        spi_dout;
    logic                 spi_trigger_out;
    logic [1:0]           dbg_state;

    logic [DW-1:0] words [NREQ];
    logic [DW-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_done = 0;

    typedef struct {
        logic [NREQ-1:0] raise;
        logic [NREQ-1:0] drop;
        int              owner;
        logic [DW-1:0]   din;
        int              delay;   // <0 silent master, 0 answer in trigger cycle
        logic [DW-1:0]   ans;
        bit              err;
        logic [DW-1:0]   rsp;
        int              gap;     // expected trigger minus previous done, 0 = skip
        bit              early;   // drop req the cycle after grant
    } vec_t;

    vec_t vecs [8];

    spi_req_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .rsp_data(rsp_data), .busy(busy),
        .spi_trigger(spi_trigger), .spi_din(spi_din), .spi_dout(spi_dout),
        .spi_trigger_out(spi_trigger_out), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = words[i];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic vec_t mk(input logic [NREQ-1:0] raise, input logic [NREQ-1:0] drop,
                                input int owner, input logic [DW-1:0] din, input int delay,
                                input logic [DW-1:0] ans, input bit e, input logic [DW-1:0] rsp,
                                input int gap, input bit early);
        vec_t v;
        v.raise = raise; v.drop = drop; v.owner = owner; v.din = din; v.delay = delay;
        v.ans = ans; v.err = e; v.rsp = rsp; v.gap = gap; v.early = early;
        return v;
    endfunction

    // One transaction: wait for the grant, play the master, check the completion
    // and the idle cycle after it. Called and returns on a falling edge.
    task automatic do_txn(input vec_t v);
        bit got, din_ok, gnt_ok, trig_ok;
        int t, d, off;
        logic [DW-1:0] saved, exp;
        req = req | v.raise;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (spi_trigger) begin got = 1; break; end
        end
        check("trigger_seen", 64'(got), 64'(1));
        if (!got) begin
            req = req & ~v.drop;
            return;
        end
        exp_q.push_back(v.rsp);
        t = cyc;
        check("grant", 64'(gnt), 64'(oh(v.owner)));
        check("spi_din", 64'(spi_din), 64'(v.din));
        check("busy_wait", 64'(busy), 64'(1));
        if (v.gap != 0) check("idle_gap", 64'(t - last_done), 64'(v.gap));
        if (v.delay == 0) begin spi_trigger_out = 1'b1; spi_dout = v.ans; end
        saved = words[v.owner];
        din_ok = 1; gnt_ok = 1; trig_ok = 1; got = 0;
        for (int k = 1; k <= TIMEOUT + 5; k++) begin
            @(negedge clk);
            spi_trigger_out = 1'b0;
            spi_dout = ~v.ans;
            if (done != '0) begin got = 1; break; end
            if (spi_din !== v.din) din_ok = 0;
            if (gnt !== oh(v.owner)) gnt_ok = 0;
            if (spi_trigger) trig_ok = 0;
            if (k == 1) begin
                words[v.owner] = ~saved;
                if (v.early) req = req & ~v.drop;
            end
            if (k == v.delay) begin spi_trigger_out = 1'b1; spi_dout = v.ans; end
        end
        check("done_seen", 64'(got), 64'(1));
        check("din_stable", 64'(din_ok), 64'(1));
        check("gnt_held", 64'(gnt_ok), 64'(1));
        check("single_trigger", 64'(trig_ok), 64'(1));
        exp = exp_q.pop_front();
        if (got) begin
            d = cyc;
            off = (v.delay >= 1 && v.delay <= TIMEOUT) ? v.delay + 1 : TIMEOUT + 1;
            check("done_cycle", 64'(d - t), 64'(off));
            check("done_owner", 64'(done), 64'(oh(v.owner)));
            check("err", 64'(err), 64'(v.err));
            check("rsp_data", 64'(rsp_data), 64'(exp));
            check("gnt_at_done", 64'(gnt), 64'(oh(v.owner)));
            last_done = d;
        end
        spi_trigger_out = 1'b1;   // spurious completion during DONE
        req = req & ~v.drop;
        words[v.owner] = saved;
        @(negedge clk);
        spi_trigger_out = 1'b0;
        check("done_cleared", 64'(done), 64'(0));
        check("gnt_cleared", 64'(gnt), 64'(0));
        check("busy_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet, got;
        rst = 1'b1;
        req = '0;
        spi_trigger_out = 1'b0;
        spi_dout = '0;
        words[0] = 32'hA5A5_A5A5;
        words[1] = 32'h1111_2222;
        words[2] = 32'h3333_4444;
        words[3] = 32'h5555_6666;

        vecs[0] = mk(4'b1111, 4'b0001, 0, 32'hA5A5_A5A5,   5, 32'hC0C0_C0C0, 0, 32'hC0C0_C0C0, 0, 0);
        vecs[1] = mk(4'b0000, 4'b0010, 1, 32'h1111_2222,   1, 32'hC1C1_C1C1, 0, 32'hC1C1_C1C1, 2, 0);
        vecs[2] = mk(4'b0000, 4'b0100, 2, 32'h3333_4444, 100, 32'hC2C2_C2C2, 0, 32'hC2C2_C2C2, 2, 0);
        vecs[3] = mk(4'b0000, 4'b1000, 3, 32'h5555_6666,   7, 32'hC3C3_C3C3, 0, 32'hC3C3_C3C3, 2, 1);
        vecs[4] = mk(4'b0001, 4'b0001, 0, 32'hA5A5_A5A5,  40, 32'h5A5A_5A5A, 0, 32'h5A5A_5A5A, 2, 0);
        vecs[5] = mk(4'b0100, 4'b0100, 2, 32'h3333_4444,  -1, 32'h0000_0000, 1, 32'h5A5A_5A5A, 2, 0);
        vecs[6] = mk(4'b0010, 4'b0010, 1, 32'h1111_2222,  10, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 2, 0);
        vecs[7] = mk(4'b1000, 4'b1000, 3, 32'h5555_6666,   0, 32'hDEAD_BEEF, 1, 32'h0BAD_F00D, 2, 0);

        repeat (3) @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_trigger", 64'(spi_trigger), 64'(0));
        check("rst_rsp", 64'(rsp_data), 64'(0));
        check("rst_din", 64'(spi_din), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Late completion while idle must not produce a done.
        spi_trigger_out = 1'b1;
        spi_dout = 32'h7777_7777;
        @(negedge clk);
        spi_trigger_out = 1'b0;
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (done != '0 || busy || spi_trigger) quiet = 0;
        end
        check("idle_spurious", 64'(quiet), 64'(1));
        check("idle_rsp_kept", 64'(rsp_data), 64'(32'h0BAD_F00D));
        check("idle_err_kept", 64'(err), 64'(1));

        // Fairness: 1 and 3 held continuously, ptr starts at 0.
        do_txn(mk(4'b1010, 4'b0000, 1, 32'h1111_2222, 3, 32'hF000_0001, 0, 32'hF000_0001, 0, 0));
        do_txn(mk(4'b0000, 4'b0000, 3, 32'h5555_6666, 3, 32'hF000_0002, 0, 32'hF000_0002, 2, 0));
        do_txn(mk(4'b0000, 4'b0000, 1, 32'h1111_2222, 3, 32'hF000_0003, 0, 32'hF000_0003, 2, 0));
        do_txn(mk(4'b0000, 4'b0000, 3, 32'h5555_6666, 3, 32'hF000_0004, 0, 32'hF000_0004, 2, 0));
        do_txn(mk(4'b0000, 4'b1010, 1, 32'h1111_2222, 3, 32'hF000_0005, 0, 32'hF000_0005, 2, 0));

        // Reset mid-WAIT: ptr is 2 here, so the pre-reset grant goes to 2.
        req = 4'b0101;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (spi_trigger) begin got = 1; break; end
        end
        check("pre_reset_trigger", 64'(got), 64'(1));
        check("pre_reset_gnt", 64'(gnt), 64'(4'b0100));
        quiet = 1;
        repeat (10) begin
            @(negedge clk);
            if (done != '0) quiet = 0;
        end
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_gnt", 64'(gnt), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_trigger", 64'(spi_trigger), 64'(0));
        check("mid_rst_err", 64'(err), 64'(0));
        check("mid_rst_rsp", 64'(rsp_data), 64'(0));
        check("mid_rst_din", 64'(spi_din), 64'(0));
        spi_trigger_out = 1'b1;   // stale answer from the abandoned transfer
        spi_dout = 32'h9999_9999;
        @(negedge clk);
        spi_trigger_out = 1'b0;
        if (done != '0 || busy) quiet = 0;
        @(negedge clk);
        if (done != '0 || busy) quiet = 0;
        check("reset_no_done", 64'(quiet), 64'(1));
        do_txn(mk(4'b0101, 4'b0001, 0, 32'hA5A5_A5A5, 4, 32'h1234_5678, 0, 32'h1234_5678, 0, 0));
        do_txn(mk(4'b0000, 4'b0100, 2, 32'h3333_4444, 6, 32'h8765_4321, 0, 32'h8765_4321, 2, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_req_arbiter.md
# spi_req_arbiter

Round-robin arbiter and sequencer that shares one 32-bit SPI master transaction engine (trigger/din in, dout/trigger_out back) among NREQ requesters. It grants one requester at a time and launches the master with a single-cycle trigger. It returns the received word and a completion pulse to the owner, and aborts with an error flag if the master does not answer within a bounded time. It sits between the command sources and the SPI top-level datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 32, transaction word width
- TIMEOUT, 4096, max cycles to wait for master completion after trigger
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req  in  NREQ  level request per requester; held until that requester's done pulse
- req_data  in  NREQ*DW  requester i word at bits i*DW .. i*DW+DW-1
- gnt  out  NREQ  one-hot owner, high from grant through done cycle
- done  out  NREQ  one-cycle completion pulse to owner
- err  out  1  qualifies done: 1 = timeout, 0 = normal; held until next completion
- rsp_data  out  DW  word captured from master; held until next normal completion
- busy  out  1  high in any state other than IDLE
- spi_trigger  out  1  one-cycle start pulse to master
- spi_din  out  DW  word to transmit; stable from trigger until completion
- spi_dout  in  DW  master received word, valid when spi_trigger_out high
- spi_trigger_out  in  1  master completion pulse

## Operation
- States: IDLE, WAIT, DONE. Round-robin pointer ptr (0..NREQ-1) is the highest-priority index.
- IDLE: if any req bit is set, select the first set index scanning ptr, ptr+1, ... (wrapping mod NREQ). On that edge:
  - gnt <= one-hot(winner)
  - spi_din <= req_data[winner]
  - spi_trigger <= 1
  - timer <= 0
  - state <= WAIT
- WAIT:
  - spi_trigger <= 0 after its single cycle; timer increments each cycle.
  - spi_trigger_out is ignored in the trigger cycle itself.
  - On spi_trigger_out, from the cycle after trigger onward: rsp_data <= spi_dout, err <= 0, done[owner] <= 1, state <= DONE.
  - Else, if timer == TIMEOUT: err <= 1, done[owner] <= 1, rsp_data unchanged, state <= DONE.
  - If spi_trigger_out and timeout coincide, the normal completion wins.
- DONE: done <= 0, gnt <= 0, ptr <= (owner+1) mod NREQ, state <= IDLE.
- Requester dropping req mid-transaction: ignored; the transaction completes and done is still pulsed.
- req_data changes after grant do not affect spi_din.
- spi_trigger_out in IDLE or DONE (late or spurious) is ignored; no state change.
- Requester must deassert req by the edge ending its done cycle, or it is re-granted when its turn recurs.

## Timing
- Reset (rst sampled high): state IDLE, ptr 0, timer 0; gnt, done, err, busy, spi_trigger all 0; rsp_data and spi_din 0.
- Reset mid-transaction abandons it with no done pulse. This block does not reset the master; a later spi_trigger_out is ignored.
- req visible in cycle R: gnt and spi_trigger high in cycle T = R+1; busy high from T.
- spi_trigger_out accepted in cycles T+1 .. T+TIMEOUT. Arrival in cycle C: done/rsp_data/err valid in cycle C+1, gnt still high.
- No answer: done with err=1 in cycle T+TIMEOUT+1.
- IDLE resumes in the cycle after done. The earliest next spi_trigger is 2 cycles after the done cycle, so one idle cycle always separates transactions.
- timer width: ceil(log2(TIMEOUT+1)) bits; it never wraps.

## Test plan
- Single transfer: req[0]=1, word A5A5A5A5, master model answers 5A5A5A5A after 40 cycles. Expect:
  - exactly one spi_trigger pulse with spi_din=A5A5A5A5
  - done[0] for one cycle with err=0 and rsp_data=5A5A5A5A
  - gnt=0001 throughout
- All four req raised in the same cycle with distinct words, each dropped on its done. Expect grants 0,1,2,3 in order, each spi_din matching the owner, and one idle cycle between a done and the next trigger.
- Fairness: req[1] and req[3] held continuously (re-raised after done). Expect grants alternating 3,1,3,1 after the first grant to 1, with requesters 0 and 2 never granted.
- Timeout with TIMEOUT=100 and a silent master. Expect:
  - done with err=1 exactly 101 cycles after the trigger cycle
  - rsp_data unchanged
  - the next request is granted normally
  - a late spi_trigger_out while IDLE causes no done
- Boundary: spi_trigger_out in cycle T+100 with TIMEOUT=100 gives err=0 and captures data. spi_trigger_out in cycle T itself is ignored, and the timeout then fires.
- Reset mid-WAIT: rst pulsed 10 cycles after trigger. Expect all outputs 0 the next cycle, no done, ptr=0 (next simultaneous req 0 and 2 grants 0), and a stale spi_trigger_out ignored.
